// File: rtl/mem_responder_if.sv
// Request/response bus between the core controller and mem_responder.
// Signal names match the controller's existing request and response port names.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, then
// performs the access on a word-addressed RAM and holds the response until it is taken.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic              accept;
  logic              exec;
  logic              use_bus;
  logic              ex_we;
  logic              ex_err;
  logic [31:0]       ex_addr;
  logic [31:0]       ex_wdata;
  logic [3:0]        ex_be;
  logic [ADDR_W-1:0] ex_idx;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        // rsp_valid trails RESP entry by one edge, giving the LATENCY+1 response timing.
        if (rsp_valid_q && bus.rsp_ready) state_d     = IDLE;
        else                              rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Execute stage: with LATENCY==0 the access happens on the accept edge, so use the live bus.
  assign exec     = (state_d == RESP) && (state_q != RESP);
  assign use_bus  = (state_q == IDLE);
  assign ex_we    = use_bus ? bus.req_we    : we_q;
  assign ex_addr  = use_bus ? bus.req_addr  : addr_q;
  assign ex_wdata = use_bus ? bus.req_wdata : wdata_q;
  assign ex_be    = use_bus ? bus.req_be    : be_q;
  assign ex_err   = (ex_addr[1:0] != 2'b00) || ((ex_addr >> (ADDR_W + 2)) != 32'd0);
  assign ex_idx   = ex_addr[ADDR_W+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      if (exec) begin
        err_q   <= ex_err;
        rdata_q <= (ex_we || ex_err) ? 32'd0 : mem[ex_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (exec && ex_we && !ex_err) begin
      for (int i = 0; i < 4; i++) begin
        if (ex_be[i]) mem[ex_idx][8*i +: 8] <= ex_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table on a LATENCY=2 instance plus
// hand-written backpressure, reset-abort and LATENCY=0 throughput sequences.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_responder_if if2 ();
  mem_responder_if if0 ();

  mem_responder #(.ADDR_W(10), .LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(if2));
  mem_responder #(.ADDR_W(10), .LATENCY(0)) u_lat0 (.clk(clk), .rst(rst), .bus(if0));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request on the LATENCY=2 instance; returns at the negedge where rsp_valid is first seen.
  // lat is the number of edges after the accept edge at which rsp_valid was observed.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic rr,
                      output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    if2.req_valid = 1'b1;
    if2.req_we    = we;
    if2.req_addr  = addr;
    if2.req_wdata = wdata;
    if2.req_be    = be;
    if2.rsp_ready = rr;
    @(posedge clk);
    #1;
    if2.req_valid = 1'b0;
    if2.req_we    = ~we;
    if2.req_addr  = 32'hFFFF_FFFF;
    if2.req_wdata = 32'h5A5A_5A5A;
    if2.req_be    = 4'hF;
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!if2.rsp_valid && lat < 40);
    rdata = if2.rsp_rdata;
    err   = if2.rsp_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          acc [$];

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'h5555_5555, 4'h0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEAA, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h6, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDE22_33AA, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0123_4567, 4'hF, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'h0123_4567, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b0};

    if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_addr = '0; if2.req_wdata = '0;
    if2.req_be = '0; if2.rsp_ready = 1'b0;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
    if0.req_be = '0; if0.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", if2.req_ready, 1'b1);
    check("rst_rsp_valid", if2.rsp_valid, 1'b0);
    check("rst_rsp_rdata", if2.rsp_rdata, 32'd0);
    check("rst_rsp_err",   if2.rsp_err,   1'b0);
    check("rst_busy",      if2.busy,      1'b0);
    check("rst0_req_ready", if0.req_ready, 1'b1);
    check("rst0_rsp_valid", if0.rsp_valid, 1'b0);
    rst = 1'b0;

    // Vector table on the LATENCY=2 instance
    for (int i = 0; i < 16; i++) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b1, rd, er, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
    end

    // Backpressure: response held for 5 cycles, a competing request must not be accepted
    xact(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er, lat);
    check("bp_latency", lat, 32'd3);
    check("bp_rdata0", rd, 32'hDE22_33AA);
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 32'h10;
    if2.req_wdata = 32'h0; if2.req_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_rsp_valid", k), if2.rsp_valid, 1'b1);
      check($sformatf("bp%0d_rdata", k), if2.rsp_rdata, 32'hDE22_33AA);
      check($sformatf("bp%0d_err", k), if2.rsp_err, 1'b0);
      check($sformatf("bp%0d_req_ready", k), if2.req_ready, 1'b0);
    end
    if2.req_valid = 1'b0;
    if2.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done_req_ready", if2.req_ready, 1'b1);
    check("bp_done_rsp_valid", if2.rsp_valid, 1'b0);
    check("bp_done_busy", if2.busy, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 1'b1, rd, er, lat);
    check("bp_after_rdata", rd, 32'hDE22_33AA);

    // Reset during WAIT aborts the write
    @(negedge clk);
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 32'h20;
    if2.req_wdata = 32'h1234_5678; if2.req_be = 4'hF; if2.rsp_ready = 1'b1;
    @(posedge clk);
    #1 if2.req_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", if2.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rstw_req_ready", if2.req_ready, 1'b1);
    check("rstw_rsp_valid", if2.rsp_valid, 1'b0);
    check("rstw_rsp_rdata", if2.rsp_rdata, 32'd0);
    check("rstw_rsp_err",   if2.rsp_err,   1'b0);
    check("rstw_busy",      if2.busy,      1'b0);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 32'h20, 32'h0, 4'hF, 1'b1, rd, er, lat);
    check("rstw_read_rdata", rd, 32'hCAFE_F00D);
    check("rstw_read_err", er, 1'b0);

    // Reset during RESP drops the response but keeps the committed write
    xact(1'b1, 32'h24, 32'h0BAD_F00D, 4'hF, 1'b0, rd, er, lat);
    check("rstr_latency", lat, 32'd3);
    rst = 1'b1;
    #1;
    check("rstr_rsp_valid", if2.rsp_valid, 1'b0);
    check("rstr_busy", if2.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 32'h24, 32'h0, 4'hF, 1'b1, rd, er, lat);
    check("rstr_read_rdata", rd, 32'h0BAD_F00D);

    // LATENCY=0: single write, then back-to-back reads with req_valid held high
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = 1'b1; if0.req_addr = 32'h8;
    if0.req_wdata = 32'h0000_0077; if0.req_be = 4'hF; if0.rsp_ready = 1'b1;
    @(posedge clk);
    #1 if0.req_valid = 1'b0;
    lat = -1;
    do begin
      @(negedge clk);
      lat++;
    end while (!if0.rsp_valid && lat < 40);
    check("l0_latency", lat, 32'd1);
    check("l0_write_rdata", if0.rsp_rdata, 32'd0);
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_addr = 32'h8;
    for (int n = 0; n < 14; n++) begin
      if (if0.req_ready) acc.push_back(n);
      if (if0.rsp_valid) check($sformatf("l0_read%0d_rdata", n), if0.rsp_rdata, 32'h0000_0077);
      @(negedge clk);
    end
    if0.req_valid = 1'b0;
    check("l0_accept_count", acc.size(), 32'd5);
    for (int j = 1; j < acc.size(); j++)
      check($sformatf("l0_accept_gap%0d", j), acc[j] - acc[j-1], 32'd3);
    repeat (4) @(negedge clk);
    check("l0_idle_busy", if0.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
